// File: rtl/pe_row_conv_core_if.sv
// Streaming channels of the row-stationary PE: filter load, ifmap load, psum in and psum out.
// Each channel transfers on a rising edge where valid & ready are both high; a source holds
// valid and data steady until that transfer, and ready may depend on state but never on valid.
interface pe_row_conv_core_if #(
   parameter int DW    = 16,
   parameter int ACC_W = 32
);
   logic             fil_valid;
   logic             fil_ready;
   logic [DW-1:0]    fil_data;
   logic             map_valid;
   logic             map_ready;
   logic [DW-1:0]    map_data;
   logic             psum_in_valid;
   logic             psum_in_ready;
   logic [ACC_W-1:0] psum_in_data;
   logic             psum_out_valid;
   logic             psum_out_ready;
   logic [ACC_W-1:0] psum_out_data;

   modport master (
      output fil_valid, fil_data, map_valid, map_data,
      output psum_in_valid, psum_in_data, psum_out_ready,
      input  fil_ready, map_ready, psum_in_ready, psum_out_valid, psum_out_data
   );

   modport slave (
      input  fil_valid, fil_data, map_valid, map_data,
      input  psum_in_valid, psum_in_data, psum_out_ready,
      output fil_ready, map_ready, psum_in_ready, psum_out_valid, psum_out_data
   );
endinterface

// File: rtl/pe_row_conv_core.sv
// One PE of a 1-D row-stationary convolution: buffers a filter row and an ifmap row, computes
// E = W-S+1 partial sums through a 3-stage MAC pipeline, then streams them out plus the neighbour psum.
module pe_row_conv_core #(
   parameter int DW       = 16,
   parameter int ACC_W    = 32,
   parameter int FL_DEPTH = 12,
   parameter int IF_DEPTH = 16,
   localparam int SW      = $clog2(FL_DEPTH + 1),
   localparam int WW      = $clog2(IF_DEPTH + 1)
) (
   input  logic                 CLK,
   input  logic                 clr_,
   input  logic                 start,
   input  logic [SW-1:0]        cfg_s,
   input  logic [WW-1:0]        cfg_w,
   input  logic                 cfg_first,
   pe_row_conv_core_if.slave    bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [15:0]          zero_skip_cnt,
   output logic [2:0]           o_dbg_state
);
   localparam int FAW = $clog2(FL_DEPTH);
   localparam int MAW = $clog2(IF_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t                  r_state;
   logic [SW-1:0]           r_s, r_fcnt, r_k;
   logic [WW-1:0]           r_w, r_e, r_mcnt, r_j;
   logic                    r_first;
   logic signed [DW-1:0]    r_filt [FL_DEPTH];
   logic signed [DW-1:0]    r_map  [IF_DEPTH];
   logic [FL_DEPTH-1:0]     r_fzero;
   logic [IF_DEPTH-1:0]     r_mzero;
   logic [ACC_W-1:0]        r_acc  [IF_DEPTH];
   logic signed [DW-1:0]    r_op_f, r_op_m;
   logic                    r_v1, r_ld1, r_z1;
   logic [MAW-1:0]          r_j1;
   logic signed [2*DW-1:0]  r_prod;
   logic                    r_v2, r_ld2;
   logic [MAW-1:0]          r_j2;
   logic                    r_dcnt;
   logic                    r_pov;
   logic [ACC_W-1:0]        r_pod;
   logic                    r_done, r_err;
   logic [15:0]             r_zcnt;

   logic                    w_cfg_ok;
   logic                    w_fil_rdy, w_map_rdy, w_pin_rdy;
   logic [MAW-1:0]          w_mac_addr;
   logic                    w_mac_zero;
   logic                    w_k_last, w_j_last;
   logic signed [2*DW-1:0]  w_mult;
   logic [ACC_W-1:0]        w_prod_ext;
   logic [ACC_W-1:0]        w_pin_add;

   assign w_cfg_ok   = (cfg_s != '0) && (32'(cfg_s) <= 32'(FL_DEPTH)) &&
                       (32'(cfg_s) <= 32'(cfg_w)) && (32'(cfg_w) <= 32'(IF_DEPTH));
   assign w_fil_rdy  = (r_state == S_LOAD) && (r_fcnt != r_s);
   assign w_map_rdy  = (r_state == S_LOAD) && (r_mcnt != r_w);
   assign w_pin_rdy  = (r_state == S_OUT) && !r_pov;
   assign w_mac_addr = r_j[MAW-1:0] + MAW'(r_k);
   assign w_mac_zero = r_mzero[w_mac_addr] | r_fzero[r_k[FAW-1:0]];
   assign w_k_last   = (r_k == r_s - SW'(1));
   assign w_j_last   = (r_j == r_e - WW'(1));
   assign w_mult     = r_op_f * r_op_m;
   assign w_prod_ext = ACC_W'(r_prod);
   assign w_pin_add  = r_first ? '0 : bus.psum_in_data;

   assign bus.fil_ready      = w_fil_rdy;
   assign bus.map_ready      = w_map_rdy;
   assign bus.psum_in_ready  = w_pin_rdy;
   assign bus.psum_out_valid = r_pov;
   assign bus.psum_out_data  = r_pod;
   assign busy               = (r_state != S_IDLE);
   assign done               = r_done;
   assign err                = r_err;
   assign zero_skip_cnt      = r_zcnt;
   assign o_dbg_state        = r_state;

   always_ff @(posedge CLK or negedge clr_) begin
      if (!clr_) begin
         r_state <= S_IDLE;
         r_s     <= '0;
         r_w     <= '0;
         r_e     <= '0;
         r_first <= 1'b0;
         r_fcnt  <= '0;
         r_mcnt  <= '0;
         r_k     <= '0;
         r_j     <= '0;
         r_fzero <= '0;
         r_mzero <= '0;
         for (int i = 0; i < FL_DEPTH; i++) r_filt[i] <= '0;
         for (int i = 0; i < IF_DEPTH; i++) r_map[i] <= '0;
         for (int i = 0; i < IF_DEPTH; i++) r_acc[i] <= '0;
         r_op_f  <= '0;
         r_op_m  <= '0;
         r_v1    <= 1'b0;
         r_ld1   <= 1'b0;
         r_z1    <= 1'b0;
         r_j1    <= '0;
         r_prod  <= '0;
         r_v2    <= 1'b0;
         r_ld2   <= 1'b0;
         r_j2    <= '0;
         r_dcnt  <= 1'b0;
         r_pov   <= 1'b0;
         r_pod   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_zcnt  <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_v1   <= 1'b0;
         // Stages 2 and 3 free-run; a gated pair carries a zero product but still lands in acc.
         r_v2   <= r_v1;
         r_ld2  <= r_ld1;
         r_j2   <= r_j1;
         r_prod <= r_z1 ? '0 : w_mult;
         if (r_v2) r_acc[r_j2] <= r_ld2 ? w_prod_ext : r_acc[r_j2] + w_prod_ext;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_cfg_ok) begin
                     r_s     <= cfg_s;
                     r_w     <= cfg_w;
                     r_e     <= cfg_w - WW'(cfg_s) + WW'(1);
                     r_first <= cfg_first;
                     r_fcnt  <= '0;
                     r_mcnt  <= '0;
                     r_fzero <= '0;
                     r_mzero <= '0;
                     r_zcnt  <= '0;
                     r_state <= S_LOAD;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (w_fil_rdy && bus.fil_valid) begin
                  r_filt[r_fcnt[FAW-1:0]]  <= bus.fil_data;
                  r_fzero[r_fcnt[FAW-1:0]] <= (bus.fil_data == '0);
                  r_fcnt                   <= r_fcnt + SW'(1);
               end
               if (w_map_rdy && bus.map_valid) begin
                  r_map[r_mcnt[MAW-1:0]]   <= bus.map_data;
                  r_mzero[r_mcnt[MAW-1:0]] <= (bus.map_data == '0);
                  r_mcnt                   <= r_mcnt + WW'(1);
               end
               if (r_fcnt == r_s && r_mcnt == r_w) begin
                  r_j     <= '0;
                  r_k     <= '0;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               r_v1  <= 1'b1;
               r_ld1 <= (r_k == '0);
               r_j1  <= r_j[MAW-1:0];
               r_z1  <= w_mac_zero;
               // Holding the operands on a gated pair keeps the multiplier inputs quiet.
               if (w_mac_zero) begin
                  if (r_zcnt != 16'hFFFF) r_zcnt <= r_zcnt + 16'd1;
               end else begin
                  r_op_f <= r_filt[r_k[FAW-1:0]];
                  r_op_m <= r_map[w_mac_addr];
               end
               if (w_k_last) begin
                  r_k <= '0;
                  if (w_j_last) begin
                     r_dcnt  <= 1'b0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_j <= r_j + WW'(1);
                  end
               end else begin
                  r_k <= r_k + SW'(1);
               end
            end
            S_DRAIN: begin
               r_dcnt <= 1'b1;
               if (r_dcnt) begin
                  r_j     <= '0;
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               if (w_pin_rdy && bus.psum_in_valid) begin
                  r_pod <= r_acc[r_j[MAW-1:0]] + w_pin_add;
                  r_pov <= 1'b1;
               end else if (r_pov && bus.psum_out_ready) begin
                  r_pov <= 1'b0;
                  if (w_j_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_j <= r_j + WW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
